surfturf_cmd_bridge: RTL and testbench
======================================

Name: surfturf_cmd_bridge

Overview:
- Wishbone-target bridge that turns register writes into per-channel AXI4-Stream command words.
- Each of NCH channels has its own DEPTH-entry FIFO, with fill counts, sticky overflow flags and per-channel flush.
- Single clock; the sysclk-side consumers receive streams that are already in the wb domain.
- Generalises the fixed runcmd/trig single-holding-register path to N buffered channels of parametrised width.

Parameters:
NCH, 2, number of command channels (1..8)
DATA_BITS, 16, command word width per channel (1..32)
DEPTH, 4, FIFO entries per channel (power of two, 2..16)
ADR_BITS, 10, wishbone address width (must cover 4*(NCH+1) bytes)

Ports:
wb_clk_i  in  1  system/bus clock
wb_rst_i  in  1  asynchronous active-high reset
wb_cyc_i  in  1  wishbone cycle
wb_stb_i  in  1  wishbone strobe
wb_adr_i  in  ADR_BITS  byte address; bits [ADR_BITS-1:2] select register
wb_dat_i  in  32  write data
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte selects
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  tied 0
wb_rty_o  out  1  tied 0
cmd_tdata  out  NCH*DATA_BITS  channel k occupies [k*DATA_BITS +: DATA_BITS]
cmd_tvalid  out  NCH  per-channel valid
cmd_tready  in  NCH  per-channel ready

Behaviour:
- Reset (async assert, sync release to wb_clk_i) clears:
  - ack, wb_dat_o=0
  - all FIFOs: pointers 0, counts 0
  - cmd_tvalid=0, cmd_tdata=0
  - overflow flags=0
- Bus timing:
  - Internal ack_r <= cyc&stb&!wb_ack_o; wb_ack_o = ack_r & cyc.
  - One ack per access; latency 1 cycle.
  - All register side effects occur only on the cycle wb_ack_o=1.
  - wb_dat_o is registered and valid with ack.
- Register 0 (CONTROL, addr 0x0):
  - Write: bits [NCH-1:0] = flush channel k (1-cycle pulse; write 1 acts, no state retained). Bits [16+k] write-1-to-clear overflow k. Write requires wb_sel_i[0] for flush and wb_sel_i[2] for clear.
  - Read: [NCH-1:0] empty_k; [8+k] full_k; [16+k] overflow_k; others 0.
- Register k+1 (CHAN k, addr 4*(k+1)):
  - Write pushes wb_dat_i[DATA_BITS-1:0] into FIFO k.
  - The push requires wb_sel_i set for all bytes 0..ceil(DATA_BITS/8)-1. Partial-sel writes are acked, cause no push and do not set overflow.
  - Read returns {27'b0, count_k[4:0]}; count range 0..DEPTH.
- Unmapped addresses: read 0, writes ignored, still acked.
- Stream side:
  - cmd_tvalid[k] = count_k!=0; cmd_tdata shows the FIFO head.
  - Pop on tvalid&tready. Head data is stable while tvalid&!tready.
  - Push acked at cycle T yields tvalid at T+1 (first-word latency 1).
- Full:
  - Push when count_k==DEPTH is dropped and sets overflow_k sticky, even if a pop occurs the same cycle.
  - Simultaneous push and pop with count<DEPTH: count unchanged, both take effect.
- Empty: no pop possible; tready while empty is ignored.
- Flush:
  - Flush of channel k clears its pointers/count next cycle; overflow_k is not affected.
  - Flush has priority over push and pop to the same channel in the same cycle.
  - Only CONTROL writes flush, so a same-cycle push is impossible; a same-cycle pop is discarded.
- Overflow: set has priority over a same-cycle clear.
- Pointers wrap modulo DEPTH; count is width $clog2(DEPTH)+1.
- Reset mid-transfer: an outstanding ack is dropped and the master must retry. Streams go invalid immediately, asynchronously.

Test Plan:
- NCH=2, DATA_BITS=16, DEPTH=4: write 0x1234 to 0x4 with sel=0xF, tready[0]=1 -> ack one cycle after stb; cmd_tvalid[0] high exactly 1 cycle later with tdata[15:0]=0x1234; then count returns 0.
- tready[1]=0: write 1,2,3,4,5 to 0x8 -> count reg reads 4; CONTROL[9]=1 and [17]=1. Raise tready -> outputs 1,2,3,4 in order, 5 is lost.
- Channel 1 holding 2 entries: write CONTROL=0x2 -> next cycle tvalid[1]=0, count=0; overflow bit 17 still set. Write CONTROL=0x20000 -> bit 17 cleared.
- Write to 0x4 with sel=0x1 (DATA_BITS=16) -> acked, count stays 0, no overflow. Then sel=0x3 -> pushed.
- Channel 0 full with tready=1 and a push on the pop cycle -> push dropped, overflow set, count goes 4->3. With count 2 under the same stimulus -> count stays 2.
- Assert wb_rst_i asynchronously mid-stream with tvalid=1 -> tvalid and tdata go 0 without a clock edge; after release all counts read 0 and CONTROL reads 0x3.

Source files
------------

// File: rtl/surfturf_cmd_bridge_if.sv
// Wishbone target bus plus per-channel command streams for surfturf_cmd_bridge.
// master = bus initiator and stream consumer, slave = the bridge.
interface surfturf_cmd_bridge_if #(
    parameter int NCH       = 2,
    parameter int DATA_BITS = 16,
    parameter int ADR_BITS  = 10
);
    logic                     wb_cyc_i;
    logic                     wb_stb_i;
    logic [ADR_BITS-1:0]      wb_adr_i;
    logic [31:0]              wb_dat_i;
    logic                     wb_we_i;
    logic [3:0]               wb_sel_i;
    logic [31:0]              wb_dat_o;
    logic                     wb_ack_o;
    logic                     wb_err_o;
    logic                     wb_rty_o;
    logic [NCH*DATA_BITS-1:0] cmd_tdata;
    logic [NCH-1:0]           cmd_tvalid;
    logic [NCH-1:0]           cmd_tready;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, cmd_tready,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, cmd_tdata, cmd_tvalid
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, cmd_tready,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, cmd_tdata, cmd_tvalid
    );
endinterface

// File: rtl/surfturf_cmd_bridge.sv
// Wishbone target that turns register writes into per-channel command stream words,
// each channel buffered in a DEPTH-entry FIFO with fill count, sticky overflow and flush.
module surfturf_cmd_bridge #(
    parameter int NCH       = 2,
    parameter int DATA_BITS = 16,
    parameter int DEPTH     = 4,
    parameter int ADR_BITS  = 10
) (
    input logic                  wb_clk_i,
    input logic                  wb_rst_i,
    surfturf_cmd_bridge_if.slave bus
);
    localparam int         PW       = $clog2(DEPTH);
    localparam int         CW       = PW + 1;
    localparam int         RW       = ADR_BITS - 2;
    localparam int         NBYTES   = (DATA_BITS + 7) / 8;
    localparam logic [3:0] PUSH_SEL = 4'((1 << NBYTES) - 1);

    logic [1:0] rst_sync;
    logic       rst;

    // Assertion reaches every flop immediately; release is aligned to wb_clk_i.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) rst_sync <= 2'b11;
        else          rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst = rst_sync[1];

    logic              ack_r;
    logic [31:0]       dat_r;
    logic [31:0]       rd_data;
    logic              acc_req;
    logic              wr_acc;
    logic              ctrl_wr;
    logic [RW-1:0]     reg_idx;

    logic [NCH-1:0]          flush;
    logic [NCH-1:0]          ovf_clr;
    logic [NCH-1:0]          empty;
    logic [NCH-1:0]          full;
    logic [NCH-1:0]          ovf;
    logic [NCH-1:0][CW-1:0]  cnt_all;

    assign reg_idx      = bus.wb_adr_i[ADR_BITS-1:2];
    assign acc_req      = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_ack_o;
    assign bus.wb_ack_o = ack_r & bus.wb_cyc_i;
    assign bus.wb_dat_o = dat_r;
    assign bus.wb_err_o = 1'b0;
    assign bus.wb_rty_o = 1'b0;
    assign wr_acc       = bus.wb_ack_o & bus.wb_we_i;
    assign ctrl_wr      = wr_acc & (reg_idx == '0);

    always_comb begin
        rd_data = '0;
        if (reg_idx == '0) begin
            for (int k = 0; k < NCH; k++) begin
                rd_data[k]      = empty[k];
                rd_data[8 + k]  = full[k];
                rd_data[16 + k] = ovf[k];
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (reg_idx == RW'(k + 1)) rd_data = 32'(cnt_all[k]);
            end
        end
    end

    // Read data is captured on the request edge so it is valid alongside ack.
    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            ack_r <= 1'b0;
            dat_r <= '0;
        end else begin
            ack_r <= acc_req;
            if (acc_req) dat_r <= rd_data;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        logic [DATA_BITS-1:0] mem [DEPTH];
        logic [PW-1:0]        wr_ptr;
        logic [PW-1:0]        rd_ptr;
        logic [CW-1:0]        cnt;
        logic                 ovf_r;
        logic                 push;
        logic                 push_ok;
        logic                 pop;

        assign push       = wr_acc & (reg_idx == RW'(k + 1)) &
                            ((bus.wb_sel_i & PUSH_SEL) == PUSH_SEL);
        assign flush[k]   = ctrl_wr & bus.wb_sel_i[0] & bus.wb_dat_i[k];
        assign ovf_clr[k] = ctrl_wr & bus.wb_sel_i[2] & bus.wb_dat_i[16 + k];
        assign empty[k]   = (cnt == '0);
        assign full[k]    = (cnt == CW'(DEPTH));
        assign push_ok    = push & ~full[k];
        assign pop        = ~empty[k] & bus.cmd_tready[k];
        assign ovf[k]     = ovf_r;
        assign cnt_all[k] = cnt;

        assign bus.cmd_tvalid[k]                         = ~empty[k];
        assign bus.cmd_tdata[k*DATA_BITS +: DATA_BITS]   = empty[k] ? '0 : mem[rd_ptr];

        always_ff @(posedge wb_clk_i) begin
            if (push_ok) mem[wr_ptr] <= bus.wb_dat_i[DATA_BITS-1:0];
        end

        // A full-FIFO push is dropped even when a pop frees a slot on the same edge.
        always_ff @(posedge wb_clk_i or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                ovf_r  <= 1'b0;
            end else begin
                if (flush[k]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (push_ok) wr_ptr <= wr_ptr + PW'(1);
                    if (pop)     rd_ptr <= rd_ptr + PW'(1);
                    cnt <= cnt + CW'(push_ok) - CW'(pop);
                end
                if (push & full[k])  ovf_r <= 1'b1;
                else if (ovf_clr[k]) ovf_r <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.wb_adr_i[1:0], bus.wb_dat_i, bus.wb_sel_i};

endmodule

// File: tb/tb_surfturf_cmd_bridge.sv
// Bench for surfturf_cmd_bridge: directed scenarios then random bus/stream traffic,
// checked against a queue-based reference model.
module tb_surfturf_cmd_bridge;
    localparam int NCH       = 2;
    localparam int DATA_BITS = 16;
    localparam int DEPTH     = 4;
    localparam int ADR_BITS  = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    surfturf_cmd_bridge_if #(.NCH(NCH), .DATA_BITS(DATA_BITS), .ADR_BITS(ADR_BITS)) bus ();

    surfturf_cmd_bridge #(
        .NCH(NCH), .DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .ADR_BITS(ADR_BITS)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_BITS-1:0] mq [NCH][$];
    logic [NCH-1:0]       m_ovf = '0;
    bit                   m_wr = 1'b0;
    bit                   rnd_ready = 1'b0;
    logic [31:0]          last_rd;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [ADR_BITS-1:0] adr);
        logic [31:0] r;
        int          idx;
        r   = '0;
        idx = int'(adr[ADR_BITS-1:2]);
        if (idx == 0) begin
            for (int k = 0; k < NCH; k++) begin
                r[k]      = (mq[k].size() == 0);
                r[8 + k]  = (mq[k].size() == DEPTH);
                r[16 + k] = m_ovf[k];
            end
        end else if (idx <= NCH) begin
            r = 32'(mq[idx - 1].size());
        end
        return r;
    endfunction

    // One clock edge of the reference behaviour, using the values the bench is driving.
    task automatic model_step();
        int ridx;
        ridx = int'(bus.wb_adr_i[ADR_BITS-1:2]);
        for (int k = 0; k < NCH; k++) begin
            bit do_flush, do_clr, do_push, do_pop, was_full;
            do_flush = m_wr && ridx == 0 && bus.wb_sel_i[0] && bus.wb_dat_i[k];
            do_clr   = m_wr && ridx == 0 && bus.wb_sel_i[2] && bus.wb_dat_i[16 + k];
            do_push  = m_wr && ridx == k + 1 && bus.wb_sel_i[0] && bus.wb_sel_i[1];
            do_pop   = (mq[k].size() != 0) && bus.cmd_tready[k];
            was_full = (mq[k].size() == DEPTH);
            if (do_flush) begin
                mq[k].delete();
            end else begin
                if (do_pop) void'(mq[k].pop_front());
                if (do_push && !was_full) mq[k].push_back(bus.wb_dat_i[DATA_BITS-1:0]);
            end
            if (do_push && was_full) m_ovf[k] = 1'b1;
            else if (do_clr)         m_ovf[k] = 1'b0;
        end
    endtask

    task automatic check_stream();
        logic [NCH-1:0] ev;
        for (int k = 0; k < NCH; k++) ev[k] = (mq[k].size() != 0);
        check_val("tvalid", 32'(bus.cmd_tvalid), 32'(ev));
        for (int k = 0; k < NCH; k++) begin
            if (ev[k]) check_val("tdata", 32'(bus.cmd_tdata[k*DATA_BITS +: DATA_BITS]), 32'(mq[k][0]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_stream();
        if (rnd_ready) bus.cmd_tready = NCH'($urandom & $urandom);
    endtask

    task automatic bus_req(input logic we, input logic [ADR_BITS-1:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] exp;
        exp = model_read(adr);
        check_val("ack_idle", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        tick();
        check_val("ack", 32'(bus.wb_ack_o), 32'd1);
        last_rd = bus.wb_dat_o;
        if (!we) check_val("rdata", bus.wb_dat_o, exp);
    endtask

    task automatic bus_fin();
        m_wr = bus.wb_we_i;
        tick();
        m_wr = 1'b0;
        check_val("ack_once", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [ADR_BITS-1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus_req(1'b1, adr, dat, sel);
        bus_fin();
    endtask

    task automatic wb_read(input logic [ADR_BITS-1:0] adr);
        bus_req(1'b0, adr, 32'd0, 4'hF);
        bus_fin();
    endtask

    initial begin
        rst = 1'b0;
        bus.wb_cyc_i   = 1'b0;
        bus.wb_stb_i   = 1'b0;
        bus.wb_we_i    = 1'b0;
        bus.wb_adr_i   = '0;
        bus.wb_dat_i   = '0;
        bus.wb_sel_i   = '0;
        bus.cmd_tready = '0;
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        check_val("err_tied", 32'(bus.wb_err_o), 32'd0);
        check_val("rty_tied", 32'(bus.wb_rty_o), 32'd0);
        wb_read(10'h000);
        check_val("ctrl_reset", last_rd, 32'h0000_0003);
        wb_read(10'h004);

        // single word through channel 0 with consumer ready
        bus.cmd_tready = 2'b01;
        wb_write(10'h004, 32'h0000_1234, 4'hF);
        check_val("lat_tvalid", 32'(bus.cmd_tvalid[0]), 32'd1);
        check_val("lat_tdata", 32'(bus.cmd_tdata[15:0]), 32'h1234);
        tick();
        check_val("lat_popped", 32'(bus.cmd_tvalid[0]), 32'd0);
        wb_read(10'h004);
        check_val("lat_cnt", last_rd, 32'd0);

        // overfill channel 1 then drain in order
        bus.cmd_tready = 2'b00;
        for (int v = 1; v <= 5; v++) wb_write(10'h008, 32'(v), 4'hF);
        wb_read(10'h008);
        check_val("ovf_cnt", last_rd, 32'd4);
        wb_read(10'h000);
        check_val("ovf_full1", 32'(last_rd[9]), 32'd1);
        check_val("ovf_flag1", 32'(last_rd[17]), 32'd1);
        bus.cmd_tready = 2'b10;
        for (int v = 1; v <= 4; v++) begin
            check_val("drain_order", 32'(bus.cmd_tdata[31:16]), 32'(v));
            tick();
        end
        check_val("drain_empty", 32'(bus.cmd_tvalid[1]), 32'd0);
        bus.cmd_tready = 2'b00;

        // flush keeps overflow, then write-1-to-clear
        wb_write(10'h008, 32'h000A, 4'hF);
        wb_write(10'h008, 32'h000B, 4'hF);
        wb_write(10'h000, 32'h0000_0002, 4'hF);
        check_val("flush_tvalid", 32'(bus.cmd_tvalid[1]), 32'd0);
        wb_read(10'h008);
        check_val("flush_cnt", last_rd, 32'd0);
        wb_read(10'h000);
        check_val("flush_keeps_ovf", 32'(last_rd[17]), 32'd1);
        wb_write(10'h000, 32'h0002_0000, 4'hF);
        wb_read(10'h000);
        check_val("ovf_cleared", 32'(last_rd[17]), 32'd0);

        // partial byte selects do not push
        wb_write(10'h004, 32'h0000_0055, 4'h1);
        wb_read(10'h004);
        check_val("partial_sel_cnt", last_rd, 32'd0);
        wb_read(10'h000);
        check_val("partial_sel_ovf", 32'(last_rd[16]), 32'd0);
        wb_write(10'h004, 32'h0000_0066, 4'h3);
        wb_read(10'h004);
        check_val("sel3_cnt", last_rd, 32'd1);

        // push to a full FIFO on a pop edge is still dropped
        for (int v = 0; v < 3; v++) wb_write(10'h004, 32'(8'h71 + v), 4'hF);
        bus_req(1'b1, 10'h004, 32'h0099, 4'hF);
        bus.cmd_tready = 2'b01;
        bus_fin();
        bus.cmd_tready = 2'b00;
        wb_read(10'h004);
        check_val("full_pop_cnt", last_rd, 32'd3);
        wb_read(10'h000);
        check_val("full_pop_ovf", 32'(last_rd[16]), 32'd1);
        bus.cmd_tready = 2'b01;
        tick();
        bus.cmd_tready = 2'b00;
        bus_req(1'b1, 10'h004, 32'h009A, 4'hF);
        bus.cmd_tready = 2'b01;
        bus_fin();
        bus.cmd_tready = 2'b00;
        wb_read(10'h004);
        check_val("push_pop_cnt", last_rd, 32'd2);

        // asynchronous reset while a stream is valid
        check_val("pre_rst_tvalid", 32'(bus.cmd_tvalid[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("rst_tvalid", 32'(bus.cmd_tvalid), 32'd0);
        check_val("rst_tdata", 32'(bus.cmd_tdata), 32'd0);
        for (int k = 0; k < NCH; k++) mq[k].delete();
        m_ovf = '0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        wb_read(10'h000);
        check_val("ctrl_after_rst", last_rd, 32'h0000_0003);
        wb_read(10'h004);
        wb_read(10'h008);

        // random traffic with random consumer back-pressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 5) begin
                logic [3:0] sel;
                sel = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
                wb_write(ADR_BITS'(4 * $urandom_range(1, NCH + 1)), $urandom, sel);
            end else if (op < 9) begin
                if ($urandom_range(0, 3) == 0) wb_read(ADR_BITS'($urandom) & ~ADR_BITS'(3));
                else                           wb_read(ADR_BITS'(4 * $urandom_range(0, NCH + 1)));
            end else begin
                wb_write(10'h000, $urandom & 32'h0003_0003, 4'($urandom));
            end
        end
        rnd_ready = 1'b0;
        bus.cmd_tready = '1;
        repeat (DEPTH + 1) tick();
        wb_read(10'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
